// File: rtl/serial_word_rx_pkg.sv
// Shared types and constants for the serial word receiver (state encoding,
// output buffer depth, bit-counter sizing).
package serial_word_rx_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    localparam int FIFO_DEPTH = 2;

    // Width of a counter able to hold 0..width.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/word_fifo2.sv
// Two-entry synchronous word buffer; the head entry drives dout directly from a flop.
// A push together with a pop while full is accepted.
module word_fifo2
    import serial_word_rx_pkg::*;
#(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         vld,
    output logic         full
);

    localparam int CNTW = $clog2(FIFO_DEPTH + 1);

    logic [W-1:0]    head_q, head_d;
    logic [W-1:0]    tail_q, tail_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic            vld_q, vld_d;
    logic            do_pop_s;

    // Next-state for the head/tail slots and occupancy.
    always_comb begin
        head_d   = head_q;
        tail_d   = tail_q;
        cnt_d    = cnt_q;
        do_pop_s = pop & (cnt_q != CNTW'(0));
        case ({push, do_pop_s})
            2'b11: begin
                if (cnt_q == CNTW'(1)) begin
                    head_d = din;
                end else begin
                    head_d = tail_q;
                    tail_d = din;
                end
            end
            2'b10: begin
                if (cnt_q == CNTW'(0)) begin
                    head_d = din;
                    cnt_d  = CNTW'(1);
                end else if (cnt_q == CNTW'(1)) begin
                    tail_d = din;
                    cnt_d  = CNTW'(2);
                end else begin
                    cnt_d  = cnt_q;
                end
            end
            2'b01: begin
                head_d = tail_q;
                cnt_d  = cnt_q - CNTW'(1);
            end
            default: begin
                cnt_d = cnt_q;
            end
        endcase
        vld_d = (cnt_d != CNTW'(0));
    end

    // Buffer storage and registered valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_q <= {W{1'b0}};
            tail_q <= {W{1'b0}};
            cnt_q  <= {CNTW{1'b0}};
            vld_q  <= 1'b0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            cnt_q  <= cnt_d;
            vld_q  <= vld_d;
        end
    end

    assign dout = head_q;
    assign vld  = vld_q;
    assign full = (cnt_q == CNTW'(FIFO_DEPTH));

endmodule

// File: rtl/serial_word_rx.sv
// Serial-to-parallel word receiver with a 2-entry output buffer and sticky errors.
// Optional SERIAL_WORD_RX_PARITY_EN appends an even parity bit to each frame and adds perr.
module serial_word_rx
    import serial_word_rx_pkg::*;
#(
    parameter int WIDTH = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sin,
    input  logic             sin_vld,
    input  logic             frm,
    input  logic             dir,
    output logic [WIDTH-1:0] word,
    output logic             word_vld,
    input  logic             word_rdy,
    output logic             busy,
    output logic             ovf,
    output logic             ferr,
`ifdef SERIAL_WORD_RX_PARITY_EN
    output logic             perr,
`endif
    input  logic             err_clr
);

`ifdef SERIAL_WORD_RX_PARITY_EN
    localparam int FRAME = WIDTH + 1;
`else
    localparam int FRAME = WIDTH;
`endif
    localparam int CW = cnt_width(WIDTH);

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] asm_q, asm_d;
    logic             dir_q, dir_d;
    logic             ovf_q, ovf_d;
    logic             ferr_q, ferr_d;
    logic             push_s, drop_s, full_s, last_s, ferr_set_s;
    logic [WIDTH-1:0] push_word_s, shifted_s, start_s;
`ifdef SERIAL_WORD_RX_PARITY_EN
    logic             perr_q, perr_d, perr_set_s;

    function automatic logic even_parity(input logic [WIDTH-1:0] d);
        return ^d;
    endfunction
`endif

    // Frame sequencing, bit placement and error detection.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        asm_d       = asm_q;
        dir_d       = dir_q;
        push_s      = 1'b0;
        push_word_s = asm_q;
        ferr_set_s  = 1'b0;
`ifdef SERIAL_WORD_RX_PARITY_EN
        perr_set_s  = 1'b0;
`endif
        last_s    = (cnt_q == CW'(FRAME - 1));
        shifted_s = dir_q ? {sin, asm_q[WIDTH-1:1]} : {asm_q[WIDTH-2:0], sin};
        // A fresh frame starts from a cleared assembly register.
        start_s   = dir ? {sin, {(WIDTH-1){1'b0}}} : {{(WIDTH-1){1'b0}}, sin};
        case (state_q)
            IDLE: begin
                if (sin_vld && frm) begin
                    state_d = SHIFT;
                    cnt_d   = CW'(1);
                    asm_d   = start_s;
                    dir_d   = dir;
                end else begin
                    state_d = IDLE;
                end
            end
            SHIFT: begin
                if (sin_vld && frm) begin
                    ferr_set_s = 1'b1;
                    cnt_d      = CW'(1);
                    asm_d      = start_s;
                    dir_d      = dir;
                end else if (sin_vld && last_s) begin
                    state_d = IDLE;
                    cnt_d   = {CW{1'b0}};
`ifdef SERIAL_WORD_RX_PARITY_EN
                    push_word_s = asm_q;
                    perr_set_s  = even_parity(asm_q) ^ sin;
                    push_s      = ~perr_set_s;
`else
                    asm_d       = shifted_s;
                    push_word_s = shifted_s;
                    push_s      = 1'b1;
`endif
                end else if (sin_vld) begin
                    cnt_d = cnt_q + CW'(1);
                    asm_d = shifted_s;
                end else begin
                    state_d = SHIFT;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = {CW{1'b0}};
            end
        endcase
        drop_s = push_s & full_s & ~word_rdy;
        ovf_d  = drop_s | (ovf_q & ~err_clr);
        ferr_d = ferr_set_s | (ferr_q & ~err_clr);
`ifdef SERIAL_WORD_RX_PARITY_EN
        perr_d = perr_set_s | (perr_q & ~err_clr);
`endif
    end

    // Receiver state and sticky status flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= {CW{1'b0}};
            asm_q   <= {WIDTH{1'b0}};
            dir_q   <= 1'b0;
            ovf_q   <= 1'b0;
            ferr_q  <= 1'b0;
`ifdef SERIAL_WORD_RX_PARITY_EN
            perr_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            asm_q   <= asm_d;
            dir_q   <= dir_d;
            ovf_q   <= ovf_d;
            ferr_q  <= ferr_d;
`ifdef SERIAL_WORD_RX_PARITY_EN
            perr_q  <= perr_d;
`endif
        end
    end

    word_fifo2 #(.W(WIDTH)) u_fifo (
        .clk  (clk),
        .rst  (rst),
        .push (push_s),
        .din  (push_word_s),
        .pop  (word_rdy),
        .dout (word),
        .vld  (word_vld),
        .full (full_s)
    );

    assign busy = (state_q == SHIFT);
    assign ovf  = ovf_q;
    assign ferr = ferr_q;
`ifdef SERIAL_WORD_RX_PARITY_EN
    assign perr = perr_q;
`endif

endmodule

// File: tb/tb_serial_word_rx.sv
// Self-checking bench for serial_word_rx: frame table, corner-case sequences and
// randomized traffic against a queue-based reference model.
module tb_serial_word_rx;

`ifdef SERIAL_WORD_RX_PARITY_EN
    localparam int FRAME = 6;
`else
    localparam int FRAME = 5;
`endif

    logic       clk;
    logic       rst;
    logic       sin;
    logic       sin_vld;
    logic       frm;
    logic       dir;
    logic [4:0] word;
    logic       word_vld;
    logic       word_rdy;
    logic       busy;
    logic       ovf;
    logic       ferr;
    logic       err_clr;
`ifdef SERIAL_WORD_RX_PARITY_EN
    logic       perr;
`endif

    int errors = 0;
    int checks = 0;

    // Reference model state
    bit         m_bits[$];
    logic [4:0] m_fifo[$];
    bit         m_in_frame;
    bit         m_dir;
    bit         m_ovf;
    bit         m_ferr;
    bit         m_perr;

    serial_word_rx #(.WIDTH(5)) dut (
        .clk      (clk),
        .rst      (rst),
        .sin      (sin),
        .sin_vld  (sin_vld),
        .frm      (frm),
        .dir      (dir),
        .word     (word),
        .word_vld (word_vld),
        .word_rdy (word_rdy),
        .busy     (busy),
        .ovf      (ovf),
        .ferr     (ferr),
`ifdef SERIAL_WORD_RX_PARITY_EN
        .perr     (perr),
`endif
        .err_clr  (err_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       d;
        logic [4:0] bits;
        logic [4:0] exp_word;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic model_reset();
        m_bits.delete();
        m_fifo.delete();
        m_in_frame = 1'b0;
        m_dir = 1'b0;
        m_ovf = 1'b0;
        m_ferr = 1'b0;
        m_perr = 1'b0;
    endtask

    // One clock edge of the behavioural model, using the inputs held before the edge.
    task automatic model_step();
        logic [4:0] w;
        bit push;
        bit ovf_set;
        bit ferr_set;
        bit perr_set;
        bit par_ok;
        push = 0; ovf_set = 0; ferr_set = 0; perr_set = 0; w = 5'd0;
        if (rst) begin
            model_reset();
            return;
        end
        if (sin_vld) begin
            if (frm) begin
                if (m_in_frame) ferr_set = 1;
                m_bits.delete();
                m_bits.push_back(sin);
                m_dir = dir;
                m_in_frame = 1;
            end else if (m_in_frame) begin
                m_bits.push_back(sin);
                if (m_bits.size() == FRAME) begin
                    for (int i = 0; i < 5; i++) w[m_dir ? i : 4 - i] = m_bits[i];
                    par_ok = 1;
`ifdef SERIAL_WORD_RX_PARITY_EN
                    par_ok = ((^w) == m_bits[5]);
                    if (!par_ok) perr_set = 1;
`endif
                    push = par_ok;
                    m_in_frame = 0;
                    m_bits.delete();
                end
            end
        end
        if (word_rdy && m_fifo.size() > 0) void'(m_fifo.pop_front());
        if (push) begin
            if (m_fifo.size() < 2) m_fifo.push_back(w);
            else ovf_set = 1;
        end
        m_ovf  = ovf_set  | (m_ovf  & !err_clr);
        m_ferr = ferr_set | (m_ferr & !err_clr);
        m_perr = perr_set | (m_perr & !err_clr);
    endtask

    task automatic compare_model();
        chk("word_vld", word_vld, (m_fifo.size() > 0));
        if (m_fifo.size() > 0) chk("word", word, m_fifo[0]);
        chk("busy", busy, m_in_frame);
        chk("ovf", ovf, m_ovf);
        chk("ferr", ferr, m_ferr);
`ifdef SERIAL_WORD_RX_PARITY_EN
        chk("perr", perr, m_perr);
`endif
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        compare_model();
    endtask

    task automatic idle_inputs();
        sin = 1'b0; sin_vld = 1'b0; frm = 1'b0; err_clr = 1'b0;
    endtask

    // Sends bits[4] first; gap idle cycles follow each bit. Parity bit appended when enabled.
    task automatic send_frame(input logic d, input logic [4:0] bits, input bit bad_par, input int gap);
        for (int i = 0; i < FRAME; i++) begin
            sin = (i < 5) ? bits[4 - i] : ((^bits) ^ bad_par);
            sin_vld = 1'b1;
            frm = (i == 0);
            dir = d;
            cycle();
            for (int g = 0; g < gap; g++) begin
                sin_vld = 1'b0; frm = 1'b0;
                dir = ~d;
                cycle();
            end
        end
        sin_vld = 1'b0; frm = 1'b0;
    endtask

    vec_t vecs[7];

    initial begin
        vecs[0] = '{1'b0, 5'b10110, 5'b10110};
        vecs[1] = '{1'b1, 5'b10110, 5'b01101};
        vecs[2] = '{1'b0, 5'b00001, 5'b00001};
        vecs[3] = '{1'b1, 5'b00001, 5'b10000};
        vecs[4] = '{1'b1, 5'b11000, 5'b00011};
        vecs[5] = '{1'b0, 5'b11111, 5'b11111};
        vecs[6] = '{1'b1, 5'b10011, 5'b11001};

        model_reset();
        idle_inputs();
        dir = 1'b0; word_rdy = 1'b1; rst = 1'b1;
        repeat (3) cycle();
        chk("rst_word", word, 5'd0);
        chk("rst_vld", word_vld, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_ovf", ovf, 1'b0);
        chk("rst_ferr", ferr, 1'b0);
        rst = 1'b0;
        cycle();

        // Frame table, consumer always ready
        for (int v = 0; v < 7; v++) begin
            send_frame(vecs[v].d, vecs[v].bits, 1'b0, 0);
            chk("tbl_vld", word_vld, 1'b1);
            chk("tbl_word", word, vecs[v].exp_word);
            chk("tbl_busy", busy, 1'b0);
            cycle();
            chk("tbl_vld_drop", word_vld, 1'b0);
        end
        chk("tbl_ovf", ovf, 1'b0);
        chk("tbl_ferr", ferr, 1'b0);

        // Overflow: three frames into a stalled consumer
        word_rdy = 1'b0;
        send_frame(1'b0, 5'h11, 1'b0, 0);
        send_frame(1'b0, 5'h0A, 1'b0, 0);
        send_frame(1'b0, 5'h1F, 1'b0, 0);
        chk("ovf_set", ovf, 1'b1);
        chk("ovf_head", word, 5'h11);
        cycle();
        chk("ovf_hold", word, 5'h11);
        word_rdy = 1'b1;
        cycle();
        chk("ovf_second", word, 5'h0A);
        chk("ovf_second_vld", word_vld, 1'b1);
        cycle();
        chk("ovf_empty", word_vld, 1'b0);
        err_clr = 1'b1;
        cycle();
        err_clr = 1'b0;
        chk("ovf_clr", ovf, 1'b0);

        // Framing error: restart on the 3rd bit
        sin = 1'b1; sin_vld = 1'b1; frm = 1'b1; dir = 1'b0;
        cycle();
        frm = 1'b0; sin = 1'b0;
        cycle();
        send_frame(1'b0, 5'b01101, 1'b0, 0);
        chk("ferr_set", ferr, 1'b1);
        chk("ferr_word", word, 5'b01101);
        cycle();
        chk("ferr_single", word_vld, 1'b0);
        err_clr = 1'b1;
        cycle();
        err_clr = 1'b0;
        chk("ferr_clr", ferr, 1'b0);

        // Stray bits in IDLE, then a gapped frame
        for (int i = 0; i < 3; i++) begin
            sin = 1'b1; sin_vld = 1'b1; frm = 1'b0;
            cycle();
            chk("stray_busy", busy, 1'b0);
        end
        sin_vld = 1'b0;
        send_frame(1'b1, 5'b11010, 1'b0, 2);
        chk("gap_word_vld", word_vld, 1'b0);
        chk("gap_busy", busy, 1'b0);

`ifdef SERIAL_WORD_RX_PARITY_EN
        // Parity good then bad
        send_frame(1'b0, 5'b10110, 1'b0, 0);
        chk("par_good_word", word, 5'b10110);
        chk("par_good_perr", perr, 1'b0);
        cycle();
        send_frame(1'b0, 5'b10110, 1'b1, 0);
        chk("par_bad_vld", word_vld, 1'b0);
        chk("par_bad_perr", perr, 1'b1);
        err_clr = 1'b1;
        cycle();
        err_clr = 1'b0;
`endif

        // Reset with a buffered word and a frame in progress
        word_rdy = 1'b0;
        send_frame(1'b0, 5'h07, 1'b0, 0);
        sin = 1'b1; sin_vld = 1'b1; frm = 1'b1;
        cycle();
        frm = 1'b0;
        cycle();
        rst = 1'b1; sin_vld = 1'b0;
        cycle();
        rst = 1'b0;
        chk("rst_mid_vld", word_vld, 1'b0);
        chk("rst_mid_busy", busy, 1'b0);
        cycle();
        chk("rst_mid_idle", busy, 1'b0);

        // Randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            sin      = 1'($urandom_range(0, 1));
            sin_vld  = ($urandom_range(0, 99) < 70);
            frm      = ($urandom_range(0, 99) < 12);
            dir      = 1'($urandom_range(0, 1));
            word_rdy = ($urandom_range(0, 99) < 55);
            err_clr  = ($urandom_range(0, 99) < 4);
            rst      = ($urandom_range(0, 999) < 3);
            cycle();
        end
        rst = 1'b0;
        idle_inputs();
        cycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/serial_word_rx.md
# serial_word_rx

Serial-to-parallel word receiver that sits downstream of the 5-bit universal shift register. It consumes the register's serial output one bit per qualified strobe, frames bits into WIDTH-bit words and reassembles them in the configured bit order. It then presents the words to the consumer through a 2-entry valid/ready buffer. Overflow and framing errors are flagged as sticky status.

## Interface
- WIDTH, 5, data bits per word (≥2)
- clk  in  1  clock, all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- sin  in  1  serial data bit
- sin_vld  in  1  bit strobe; sin sampled only when high
- frm  in  1  frame start; qualified by sin_vld, marks first bit of a word
- dir  in  1  0: first bit lands in word bit WIDTH-1 (left-shift order); 1: first bit lands in bit 0
- word  out  WIDTH  head-of-buffer word
- word_vld  out  1  buffer non-empty
- word_rdy  in  1  consumer accepts head when word_vld & word_rdy
- busy  out  1  frame in progress
- ovf  out  1  sticky: completed word dropped, buffer full
- ferr  out  1  sticky: frm seen mid-word, partial word discarded
- err_clr  in  1  clears ovf, ferr (and perr) next cycle

## Operation
- FSM states: IDLE, SHIFT.
- IDLE:
  - sin_vld & frm: store bit 0 of frame, cnt=1, go SHIFT.
  - sin_vld & !frm: bit ignored, no flag.
- SHIFT: each sin_vld stores the bit at the position set by dir, latched at frame start. A dir change mid-frame has no effect.
- Word completion:
  - The frame completes when cnt reaches WIDTH, i.e. on the WIDTH-th accepted bit.
  - The assembled word is pushed into the buffer; FSM returns to IDLE.
- frm & sin_vld in SHIFT: partial word discarded, ferr=1, and the new frame starts with this bit (cnt=1).
- If frm arrives on what would be the completing bit, it is treated as a restart: ferr=1, no push.
- Buffer is a 2-entry FIFO, first-in first-out. A push when full and not popping in the same cycle drops the word and sets ovf=1. A push and pop in the same cycle when full succeeds.
- If err_clr and a new error occur in the same cycle, the error wins (flag stays 1).
- Unused assembly bits are cleared at frame start; no stale data is visible.

## Timing
- Reset values: word=0, word_vld=0, busy=0, ovf=0, ferr=0 (perr=0); FSM=IDLE, cnt=0, buffer empty.
- Latency: word_vld rises the cycle after the completing bit's clock edge when the buffer was empty.
- word is stable while word_vld & !word_rdy.
- Pop takes effect at the clock edge; the next entry (if any) is presented the following cycle with no bubble.
- busy is high from the cycle after frame start until the cycle after the completing bit.
- rst mid-frame or with buffered words: all state is discarded, no output pulse.
- Throughput: one bit per cycle (sin_vld continuously high) sustains one word every WIDTH cycles with word_rdy held high.

## Configuration
- SERIAL_WORD_RX_PARITY_EN:
  - When defined, a frame is WIDTH+1 bits. The last bit is even parity over the data bits.
  - On mismatch the word is not pushed and sticky output perr (1 bit, reset 0, cleared by err_clr) is set.
  - A parity-failed word never sets ovf.
- Without the macro: frame is WIDTH bits, no perr port.

## Structure
- Package serial_word_rx_pkg:
  - state enum {IDLE, SHIFT}
  - constant FIFO_DEPTH=2
  - bit-count width function, clog2(WIDTH+1)
- Sub-module word_fifo2: 2-entry parameterised sync FIFO with push/pop, full/empty, and same-cycle push+pop when full. Instantiated once.

## Test plan
- Reset, then dir=0, frm on first bit, bits 1,0,1,1,0 on consecutive cycles, word_rdy=1 → word=5'b10110, word_vld one cycle, ovf=ferr=0.
- Same bit stream with dir=1 → word=5'b01101.
- word_rdy=0, three back-to-back frames (5'h11, 5'h0A, 5'h1F) → buffer holds 5'h11, 5'h0A; 5'h1F dropped; ovf=1. Raise word_rdy → 5'h11 then 5'h0A, then word_vld=0. err_clr → ovf=0.
- frm asserted on the 3rd bit of a frame, followed by 4 more bits → ferr=1; only the new 5-bit word is pushed.
- sin_vld gapped (every 3rd cycle) and stray bits in IDLE without frm → correct word, stray bits ignored, busy spans the frame exactly.
- With SERIAL_WORD_RX_PARITY_EN: data 5'b10110 with parity 1 → pushed. The same data with parity 0 → not pushed, perr=1.
